guess_sweep_ctrl: RTL and testbench

Sequencer for the timing-attack datapath. It drives the 8-bit MCU transaction engine (`send_guess`) through a full candidate sweep for each code byte, repeating each candidate `NUM_TRIALS` times and accumulating the reply latency into a delay RAM. It then runs a sequential one-entry-per-cycle argmax scan over that RAM, commits the winning byte, and advances to the next byte position. It sits between the top-level start/LED logic and `send_guess`, and replaces the 256-wide combinational max search.

---
 rtl/guess_sweep_ctrl_pkg.sv | 26 ++
 rtl/guess_sweep_ctrl_if.sv | 24 ++
 rtl/guess_sweep_ctrl_delay_ram.sv | 23 ++
 rtl/guess_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_guess_sweep_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/guess_sweep_ctrl_pkg.sv
// Shared definitions for the timing-attack datapath: MCU protocol bytes,
// first candidate of the sweep and the sequencer state encoding.
package timing_attack_pkg;

   localparam logic [7:0] START             = 8'h01;
   localparam logic [7:0] BEGIN_GUESSING    = 8'h02;
   localparam logic [7:0] YES               = 8'h03;
   localparam logic [7:0] NO                = 8'h04;
   localparam logic [7:0] END               = 8'h05;

   // Candidates below this value collide with protocol bytes.
   localparam logic [7:0] START_GUESS_RANGE = 8'h06;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ISSUE    = 4'd1,
      S_WAIT_ACK = 4'd2,
      S_MEASURE  = 4'd3,
      S_ACCUM    = 4'd4,
      S_NEXT     = 4'd5,
      S_SCAN     = 4'd6,
      S_COMMIT   = 4'd7,
      S_DONE     = 4'd8
   } sweep_state_t;

endpackage

// File: rtl/guess_sweep_ctrl_if.sv
// Signals between the sweep sequencer, the start/LED logic and send_guess.
// master = sequencer side, slave = send_guess / MCU side.
interface guess_sweep_ctrl_if #(parameter int CODE_LEN = 2);

   logic [7:0]            data_from_mcu;
   logic                  waiting_for_reply;
   logic                  begin_transaction;
   logic [8*CODE_LEN-1:0] guess_word;
   logic [8*CODE_LEN-1:0] code;
   logic                  busy;
   logic                  done;
   logic [7:0]            cur_guess;

   modport master (
      input  data_from_mcu, waiting_for_reply,
      output begin_transaction, guess_word, code, busy, done, cur_guess
   );

   modport slave (
      output data_from_mcu, waiting_for_reply,
      input  begin_transaction, guess_word, code, busy, done, cur_guess
   );

endinterface

// File: rtl/guess_sweep_ctrl_delay_ram.sv
// 256-entry accumulated-latency store, one word per candidate byte.
// One write port, one read port with a single cycle of latency, no reset.
module delay_ram #(
   parameter int W = 26
) (
   input  logic         CLK_50,
   input  logic         we,
   input  logic [7:0]   waddr,
   input  logic [W-1:0] wdata,
   input  logic [7:0]   raddr,
   output logic [W-1:0] rdata
);

   logic [W-1:0] mem [256];

   // Registered read, write-first ordering is irrelevant: the sequencer
   // never reads an address in the cycle it is written.
   always_ff @(posedge CLK_50) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/guess_sweep_ctrl.sv
// Candidate sweep sequencer: per code byte, sends every candidate
// NUM_TRIALS times, accumulates reply latency into delay_ram, then scans
// the RAM one entry per cycle for the slowest (most-correct) candidate.
module guess_sweep_ctrl
   import timing_attack_pkg::*;
#(
   parameter int         CODE_LEN    = 2,
   parameter int         NUM_TRIALS  = 4,
   parameter logic [7:0] START_GUESS = START_GUESS_RANGE,
   parameter int         DELAY_W     = 24,
   parameter int         ACC_W       = DELAY_W + $clog2(NUM_TRIALS)
) (
   input  logic                CLK_50,
   input  logic                SW,
   guess_sweep_ctrl_if.master  bus
);

   localparam logic [3:0] IDLE     = S_IDLE;
   localparam logic [3:0] ISSUE    = S_ISSUE;
   localparam logic [3:0] WAIT_ACK = S_WAIT_ACK;
   localparam logic [3:0] MEASURE  = S_MEASURE;
   localparam logic [3:0] ACCUM    = S_ACCUM;
   localparam logic [3:0] NEXT     = S_NEXT;
   localparam logic [3:0] SCAN     = S_SCAN;
   localparam logic [3:0] COMMIT   = S_COMMIT;
   localparam logic [3:0] DONE     = S_DONE;

   localparam int BIW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int TRW = (NUM_TRIALS > 1) ? $clog2(NUM_TRIALS) : 1;

   logic [3:0]               state;
   logic [BIW-1:0]           byte_idx;
   logic [TRW-1:0]           trial;
   logic [7:0]               cand;
   logic [DELAY_W-1:0]       delay;
   logic [ACC_W-1:0]         acc, acc_nxt;
   logic [7:0]               scan_addr, rd_addr, best_byte;
   logic [ACC_W-1:0]         rd_data, best_val;
   logic                     rd_vld, ram_we;
   logic [CODE_LEN-1:0][7:0] code_r, gw;

   assign acc_nxt = acc + ACC_W'(delay);
   assign ram_we  = (state == ACCUM) && (trial == TRW'(NUM_TRIALS - 1));

   delay_ram #(.W(ACC_W)) u_ram (
      .CLK_50 (CLK_50),
      .we     (ram_we),
      .waddr  (cand),
      .wdata  (acc_nxt),
      .raddr  (scan_addr),
      .rdata  (rd_data)
   );

   // Sequencer: transaction issue, latency measurement, accumulation and argmax scan.
   always_ff @(posedge CLK_50 or posedge SW) begin
      if (SW) begin
         state     <= IDLE;
         byte_idx  <= '0;
         trial     <= '0;
         cand      <= START_GUESS;
         delay     <= '0;
         acc       <= '0;
         code_r    <= '0;
         scan_addr <= START_GUESS;
         rd_addr   <= START_GUESS;
         rd_vld    <= 1'b0;
         best_val  <= '0;
         best_byte <= START_GUESS;
      end else begin
         // A read issued in SCAN returns one cycle later, tagged with its address.
         rd_vld  <= (state == SCAN);
         rd_addr <= scan_addr;
         case (state)
            IDLE, DONE: begin
               if (bus.data_from_mcu == BEGIN_GUESSING) begin
                  byte_idx <= '0;
                  trial    <= '0;
                  acc      <= '0;
                  code_r   <= '0;
                  cand     <= START_GUESS;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               delay <= '0;
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // The acknowledging cycle is the first cycle of the reply.
               if (bus.waiting_for_reply) begin
                  delay <= DELAY_W'(1);
                  state <= MEASURE;
               end
            end
            MEASURE: begin
               if (bus.waiting_for_reply) begin
                  if (delay != '1) delay <= delay + 1'b1;
               end else begin
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (ram_we) begin
                  acc   <= '0;
                  trial <= '0;
                  state <= NEXT;
               end else begin
                  acc   <= acc_nxt;
                  trial <= trial + 1'b1;
                  state <= ISSUE;
               end
            end
            NEXT: begin
               if (cand == 8'hFF) begin
                  scan_addr <= START_GUESS;
                  best_val  <= '0;
                  best_byte <= START_GUESS;
                  state     <= SCAN;
               end else begin
                  cand  <= cand + 1'b1;
                  state <= ISSUE;
               end
            end
            SCAN: begin
               scan_addr <= scan_addr + 1'b1;
               if (rd_vld) begin
                  // Strict compare: on ties the lower candidate stays.
                  if (rd_data > best_val) begin
                     best_val  <= rd_data;
                     best_byte <= rd_addr;
                  end
                  if (rd_addr == 8'hFF) state <= COMMIT;
               end
            end
            COMMIT: begin
               code_r[byte_idx] <= best_byte;
               if (byte_idx == BIW'(CODE_LEN - 1)) begin
                  state <= DONE;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
                  cand     <= START_GUESS;
                  state    <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Guess word: committed bytes everywhere except the position under test.
   always_comb begin
      gw           = code_r;
      gw[byte_idx] = cand;
   end

   assign bus.guess_word        = gw;
   assign bus.code              = code_r;
   assign bus.cur_guess         = cand;
   assign bus.begin_transaction = (state == ISSUE) || (state == WAIT_ACK);
   assign bus.busy              = !((state == IDLE) || (state == DONE));
   assign bus.done              = (state == DONE);

endmodule

// File: tb/tb_guess_sweep_ctrl.sv
// Directed bench for guess_sweep_ctrl. Three instances:
//   u_a: default parameters, main recovery run.
//   u_b: DELAY_W=4, saturation of the per-trial counter.
//   u_c: NUM_TRIALS=1, short runs for tie / boundary / reset / restart cases.
// Each instance has its own MCU model: reply held 60 cycles when the byte at
// the position under test equals the secret, else 10 cycles. The position is
// derived from the number of transactions since the run started.
module tb_guess_sweep_ctrl;

   logic CLK_50 = 1'b0;
   logic SW     = 1'b1;
   always #10 CLK_50 = ~CLK_50;

   guess_sweep_ctrl_if #(.CODE_LEN(2)) ifa ();
   guess_sweep_ctrl_if #(.CODE_LEN(2)) ifb ();
   guess_sweep_ctrl_if #(.CODE_LEN(2)) ifc ();

   guess_sweep_ctrl u_a (.CLK_50(CLK_50), .SW(SW), .bus(ifa));
   guess_sweep_ctrl #(.DELAY_W(4)) u_b (.CLK_50(CLK_50), .SW(SW), .bus(ifb));
   guess_sweep_ctrl #(.NUM_TRIALS(1)) u_c (.CLK_50(CLK_50), .SW(SW), .bus(ifc));

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] sec_a, sec_c;
   int tcnt_a = 0, tcnt_b = 0, tcnt_c = 0;
   int base_a = 0, base_c = 0;
   int rem_a, rem_b, rem_c;
   int edges_a = 0, gw_viol_a = 0;
   logic bt_q_a = 1'b0, bt_n_a = 1'b0, wfr_n_a = 1'b0;
   logic [15:0] gw_n_a = '0;

   function automatic int reply_len(logic [15:0] gw, logic [15:0] sec, int pos);
      int p;
      logic [15:0] g, s;
      p = (pos > 1) ? 1 : pos;
      g = gw >> (8 * p);
      s = sec >> (8 * p);
      return (g[7:0] == s[7:0]) ? 60 : 10;
   endfunction

   // MCU model, instance a (1000 transactions per byte position)
   always @(posedge CLK_50 or posedge SW) begin
      if (SW) begin
         ifa.waiting_for_reply <= 1'b0;
         rem_a <= 0;
      end else if (ifa.begin_transaction && !ifa.waiting_for_reply) begin
         ifa.waiting_for_reply <= 1'b1;
         rem_a  <= reply_len(ifa.guess_word, sec_a, (tcnt_a - base_a) / 1000) - 1;
         tcnt_a <= tcnt_a + 1;
      end else if (ifa.waiting_for_reply) begin
         if (rem_a == 0) ifa.waiting_for_reply <= 1'b0;
         else rem_a <= rem_a - 1;
      end
   end

   // MCU model, instance b: every reply is 30 cycles long
   always @(posedge CLK_50 or posedge SW) begin
      if (SW) begin
         ifb.waiting_for_reply <= 1'b0;
         rem_b <= 0;
      end else if (ifb.begin_transaction && !ifb.waiting_for_reply) begin
         ifb.waiting_for_reply <= 1'b1;
         rem_b  <= 29;
         tcnt_b <= tcnt_b + 1;
      end else if (ifb.waiting_for_reply) begin
         if (rem_b == 0) ifb.waiting_for_reply <= 1'b0;
         else rem_b <= rem_b - 1;
      end
   end

   // MCU model, instance c (250 transactions per byte position)
   always @(posedge CLK_50 or posedge SW) begin
      if (SW) begin
         ifc.waiting_for_reply <= 1'b0;
         rem_c <= 0;
      end else if (ifc.begin_transaction && !ifc.waiting_for_reply) begin
         ifc.waiting_for_reply <= 1'b1;
         rem_c  <= reply_len(ifc.guess_word, sec_c, (tcnt_c - base_c) / 250) - 1;
         tcnt_c <= tcnt_c + 1;
      end else if (ifc.waiting_for_reply) begin
         if (rem_c == 0) ifc.waiting_for_reply <= 1'b0;
         else rem_c <= rem_c - 1;
      end
   end

   // begin_transaction rising edges on instance a
   always @(posedge CLK_50) begin
      bt_q_a <= ifa.begin_transaction;
      if (ifa.begin_transaction && !bt_q_a) edges_a <= edges_a + 1;
   end

   // guess_word on instance a must hold while a transaction is in flight
   always @(negedge CLK_50) begin
      if (((ifa.begin_transaction && bt_n_a) || (ifa.waiting_for_reply && wfr_n_a)) &&
          (ifa.guess_word !== gw_n_a))
         gw_viol_a <= gw_viol_a + 1;
      bt_n_a  <= ifa.begin_transaction;
      wfr_n_a <= ifa.waiting_for_reply;
      gw_n_a  <= ifa.guess_word;
   end

   task automatic test_reset();
      SW = 1'b1;
      repeat (2) @(negedge CLK_50);
      n_checks++; if (ifa.begin_transaction !== 1'b0) begin n_fail++; $display("FAIL reset_bt: got %b want 0", ifa.begin_transaction); end
      n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
      n_checks++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ifa.done); end
      n_checks++; if (ifa.code !== 16'h0000) begin n_fail++; $display("FAIL reset_code: got %h want 0000", ifa.code); end
      n_checks++; if (ifa.cur_guess !== 8'h06) begin n_fail++; $display("FAIL reset_cur_guess: got %h want 06", ifa.cur_guess); end
      n_checks++; if (ifa.guess_word !== 16'h0006) begin n_fail++; $display("FAIL reset_guess_word: got %h want 0006", ifa.guess_word); end
      SW = 1'b0;
      @(negedge CLK_50);
   endtask

   task automatic test_basic_recovery();
      int n, e0;
      sec_a = 16'hA741;
      @(negedge CLK_50);
      ifa.data_from_mcu = 8'h02;
      base_a = tcnt_a;
      e0 = edges_a;
      @(negedge CLK_50);
      ifa.data_from_mcu = 8'h00;
      n = 0;
      while (ifa.code[7:0] === 8'h00 && n < 20000) begin @(negedge CLK_50); n++; end
      n_checks++; if (ifa.code[7:0] !== 8'h41) begin n_fail++; $display("FAIL basic_byte0: got %h want 41", ifa.code[7:0]); end
      n_checks++; if (u_a.u_ram.mem[8'h41] !== 26'd240) begin n_fail++; $display("FAIL basic_ram41: got %0d want 240", u_a.u_ram.mem[8'h41]); end
      n = 0;
      while (ifa.done !== 1'b1 && n < 20000) begin @(negedge CLK_50); n++; end
      n_checks++; if (ifa.done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", ifa.done); end
      n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", ifa.busy); end
      n_checks++; if (ifa.code !== 16'hA741) begin n_fail++; $display("FAIL basic_code: got %h want a741", ifa.code); end
      n_checks++; if (edges_a - e0 !== 2000) begin n_fail++; $display("FAIL basic_bt_edges: got %0d want 2000", edges_a - e0); end
      n_checks++; if (gw_viol_a !== 0) begin n_fail++; $display("FAIL basic_gw_stable: got %0d changes want 0", gw_viol_a); end
   endtask

   task automatic test_saturation();
      int n;
      logic prev;
      @(negedge CLK_50);
      ifb.data_from_mcu = 8'h02;
      @(negedge CLK_50);
      ifb.data_from_mcu = 8'h00;
      n = 0; prev = 1'b0;
      while (!(prev && !ifb.waiting_for_reply) && n < 200) begin
         prev = ifb.waiting_for_reply;
         @(negedge CLK_50); n++;
      end
      @(negedge CLK_50);
      n_checks++; if (u_b.delay !== 4'd15) begin n_fail++; $display("FAIL sat_delay: got %0d want 15", u_b.delay); end
      n = 0;
      while (ifb.cur_guess !== 8'h07 && n < 1000) begin @(negedge CLK_50); n++; end
      n_checks++; if (u_b.u_ram.mem[8'h06] !== 6'd60) begin n_fail++; $display("FAIL sat_acc: got %0d want 60", u_b.u_ram.mem[8'h06]); end
      SW = 1'b1;
      @(negedge CLK_50);
      SW = 1'b0;
      @(negedge CLK_50);
   endtask

   task automatic start_c(input logic [15:0] sec);
      @(negedge CLK_50);
      sec_c = sec;
      ifc.data_from_mcu = 8'h02;
      base_c = tcnt_c;
      @(negedge CLK_50);
      ifc.data_from_mcu = 8'h00;
   endtask

   task automatic wait_done_c();
      int n = 0;
      while (ifc.done !== 1'b1 && n < 12000) begin @(negedge CLK_50); n++; end
      n_checks++; if (ifc.done !== 1'b1) begin n_fail++; $display("FAIL c_done_timeout: got %b want 1", ifc.done); end
   endtask

   task automatic test_all_equal();
      start_c(16'h0000);
      wait_done_c();
      n_checks++; if (ifc.code !== 16'h0606) begin n_fail++; $display("FAIL all_equal_code: got %h want 0606", ifc.code); end
   endtask

   task automatic test_boundary_and_restart();
      start_c(16'h06FF);
      n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b want 0", ifc.done); end
      n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", ifc.busy); end
      n_checks++; if (ifc.code !== 16'h0000) begin n_fail++; $display("FAIL restart_code: got %h want 0000", ifc.code); end
      wait_done_c();
      n_checks++; if (ifc.code !== 16'h06FF) begin n_fail++; $display("FAIL boundary_code: got %h want 06ff", ifc.code); end
      n_checks++; if (ifc.cur_guess !== 8'hFF) begin n_fail++; $display("FAIL boundary_no_wrap: got %h want ff", ifc.cur_guess); end
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      start_c(16'hC32B);
      while (!(ifc.cur_guess === 8'h80 && ifc.code[7:0] !== 8'h00 &&
               ifc.waiting_for_reply && !ifc.begin_transaction) && n < 12000) begin
         @(negedge CLK_50); n++;
      end
      n_checks++; if (ifc.code[7:0] !== 8'h2B) begin n_fail++; $display("FAIL midrun_byte0: got %h want 2b", ifc.code[7:0]); end
      SW = 1'b1;
      #1;
      n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", ifc.busy); end
      n_checks++; if (ifc.code !== 16'h0000) begin n_fail++; $display("FAIL midrun_code: got %h want 0000", ifc.code); end
      n_checks++; if (ifc.begin_transaction !== 1'b0) begin n_fail++; $display("FAIL midrun_bt: got %b want 0", ifc.begin_transaction); end
      n_checks++; if (ifc.guess_word !== 16'h0006) begin n_fail++; $display("FAIL midrun_guess_word: got %h want 0006", ifc.guess_word); end
      @(negedge CLK_50);
      SW = 1'b0;
      @(negedge CLK_50);
      n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: got %b want 0", ifc.busy); end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] g;
      start_c(16'hC32B);
      repeat (100) @(negedge CLK_50);
      g = ifc.cur_guess;
      ifc.data_from_mcu = 8'h02;
      repeat (3) @(negedge CLK_50);
      n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy: got %b want 1", ifc.busy); end
      n_checks++; if (ifc.cur_guess < g) begin n_fail++; $display("FAIL busy_start_cand: got %h want >= %h", ifc.cur_guess, g); end
      ifc.data_from_mcu = 8'h00;
      wait_done_c();
      n_checks++; if (ifc.code !== 16'hC32B) begin n_fail++; $display("FAIL restart_recovery_code: got %h want c32b", ifc.code); end
   endtask

   initial begin
      ifa.data_from_mcu = 8'h00;
      ifb.data_from_mcu = 8'h00;
      ifc.data_from_mcu = 8'h00;
      sec_a = 16'h0000;
      sec_c = 16'h0000;
      test_reset();
      test_basic_recovery();
      test_saturation();
      test_all_equal();
      test_boundary_and_restart();
      test_reset_mid_run();
      test_start_while_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
